// File: rtl/multi_chan_io_block_if.sv
// Programming bus between a host and multi_chan_io_block: select/strobe/address
// and write data toward the block, registered read data and ack back.
interface multi_chan_io_block_if;
  logic        io_sel;
  logic        io_sync;
  logic [19:0] io_addr;
  logic        io_rd_en;
  logic        io_wr_en;
  logic [31:0] io_wr_data;
  logic [31:0] io_rd_data;
  logic        io_rd_ack;

  modport master (
    output io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data,
    input  io_rd_data, io_rd_ack
  );

  modport slave (
    input  io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data,
    output io_rd_data, io_rd_ack
  );
endinterface

// File: rtl/multi_chan_io_block.sv
// Per-channel Aurora status/control register block: synchronized status, sticky
// event bits, saturating error counters, loopback and scratch registers.
module multi_chan_io_block #(
  parameter int NCHAN = 4,
  parameter int CNT_W = 16
) (
  input  logic                   io_clk,
  input  logic                   io_reset,
  multi_chan_io_block_if.slave   bus,
  output logic [3*NCHAN-1:0]     loopback_set,
  input  logic [NCHAN-1:0]       frame_err,
  input  logic [NCHAN-1:0]       hard_err,
  input  logic [NCHAN-1:0]       soft_err,
  input  logic [NCHAN-1:0]       channel_up,
  input  logic [NCHAN-1:0]       lane_up,
  input  logic [NCHAN-1:0]       pll_not_locked,
  input  logic [NCHAN-1:0]       tx_resetdone_out,
  input  logic [NCHAN-1:0]       rx_resetdone_out,
  input  logic [NCHAN-1:0]       link_reset_out
);
  localparam int NSTAT   = 9;
  localparam int S_CHUP  = 0;
  localparam int S_FRAME = 2;
  localparam int S_HARD  = 3;
  localparam int S_SOFT  = 4;
  localparam int S_PLL   = 5;

  typedef logic [NSTAT-1:0][NCHAN-1:0] stat_t;

  stat_t             stat_raw;
  stat_t             meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
  logic [2:0]        arm_q, arm_d;
  logic [NCHAN-1:0]  rise_frame, rise_hard, rise_soft, rise_pll, fall_chup;
  logic [3:0]        ev [NCHAN];

  logic [2:0]        loop_q   [NCHAN], loop_d   [NCHAN];
  logic [31:0]       test_q   [NCHAN], test_d   [NCHAN];
  logic [4:0]        sticky_q [NCHAN], sticky_d [NCHAN];
  logic [CNT_W-1:0]  cnt_q    [NCHAN][4], cnt_d [NCHAN][4];
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_ack_q, rd_ack_d;

  logic [3:0]        a_ch, a_off;
  logic              a_ok, wr_fire, rd_fire;
  logic [NCHAN-1:0]  wsel;
  logic [31:0]       rd_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Bit order matches the live-status register layout, LSB first.
  assign stat_raw = {link_reset_out, rx_resetdone_out, tx_resetdone_out, pll_not_locked,
                     soft_err, hard_err, frame_err, lane_up, channel_up};

  assign a_ch    = bus.io_addr[7:4];
  assign a_off   = bus.io_addr[3:0];
  assign a_ok    = (bus.io_addr[19:8] == 12'd0) && (int'(a_ch) < NCHAN);
  assign wr_fire = bus.io_sync & bus.io_sel & bus.io_wr_en;
  assign rd_fire = bus.io_sync & bus.io_sel & bus.io_rd_en;

  // arm_q fills one bit per cycle after reset; edges count only once both the
  // current and previous synchronized samples are real input samples.
  always_comb begin
    meta_d = stat_raw;
    sync_d = meta_q;
    prev_d = sync_q;
    arm_d  = {arm_q[1:0], 1'b1};
  end

  always_comb begin
    rise_frame = '0;
    rise_hard  = '0;
    rise_soft  = '0;
    rise_pll   = '0;
    fall_chup  = '0;
    if (arm_q[2]) begin
      rise_frame = sync_q[S_FRAME] & ~prev_q[S_FRAME];
      rise_hard  = sync_q[S_HARD]  & ~prev_q[S_HARD];
      rise_soft  = sync_q[S_SOFT]  & ~prev_q[S_SOFT];
      rise_pll   = sync_q[S_PLL]   & ~prev_q[S_PLL];
      fall_chup  = prev_q[S_CHUP]  & ~sync_q[S_CHUP];
    end
    for (int c = 0; c < NCHAN; c++)
      ev[c] = {fall_chup[c], rise_soft[c], rise_hard[c], rise_frame[c]};
  end

  always_comb begin
    wsel     = '0;
    loop_d   = loop_q;
    test_d   = test_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < NCHAN; c++) begin
      wsel[c] = wr_fire && a_ok && (a_ch == 4'(c));
      if (wsel[c] && a_off == 4'd1) loop_d[c] = bus.io_wr_data[2:0];
      if (wsel[c] && a_off == 4'd2) test_d[c] = bus.io_wr_data;
      if (wsel[c] && a_off == 4'd3) sticky_d[c] = sticky_q[c] & ~bus.io_wr_data[4:0];
      // Set after the W1C mask so a coincident event wins.
      sticky_d[c] = sticky_d[c] | {rise_pll[c], ev[c]};
      for (int k = 0; k < 4; k++) begin
        if (wsel[c] && a_off == 4'd8) cnt_d[c][k] = '0;
        else if (ev[c][k])            cnt_d[c][k] = sat_inc(cnt_q[c][k]);
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (a_ok && a_ch == 4'(c)) begin
        case (a_off)
          4'd0: begin
            for (int s = 0; s < NSTAT; s++) rd_word[s] = sync_q[s][c];
          end
          4'd1:    rd_word = {29'd0, loop_q[c]};
          4'd2:    rd_word = test_q[c];
          4'd3:    rd_word = {27'd0, sticky_q[c]};
          4'd4:    rd_word = 32'(cnt_q[c][0]);
          4'd5:    rd_word = 32'(cnt_q[c][1]);
          4'd6:    rd_word = 32'(cnt_q[c][2]);
          4'd7:    rd_word = 32'(cnt_q[c][3]);
          default: rd_word = '0;
        endcase
      end
    end
    rd_data_d = rd_fire ? rd_word : rd_data_q;
    rd_ack_d  = rd_fire;
  end

  always_comb begin
    loopback_set = '0;
    for (int c = 0; c < NCHAN; c++) loopback_set[3*c +: 3] = loop_q[c];
  end

  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      meta_q    <= '0;
      sync_q    <= '0;
      prev_q    <= '0;
      arm_q     <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        loop_q[c]   <= '0;
        test_q[c]   <= '0;
        sticky_q[c] <= '0;
        for (int k = 0; k < 4; k++) cnt_q[c][k] <= '0;
      end
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      arm_q     <= arm_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      loop_q    <= loop_d;
      test_q    <= test_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end

  // A reset arriving while the ack is up kills that ack immediately.
  assign bus.io_rd_ack  = rd_ack_q & ~io_reset;
  assign bus.io_rd_data = rd_data_q;
endmodule
